// File: rtl/dc_dispatch_queue_if.sv
// Issue-side bus of the decode/dispatch queue: head entry of the queue
// toward IS under a valid/ready handshake.
interface dc_dispatch_queue_if #(
    parameter int XLEN   = 32,
    parameter int PREG_W = 7,
    parameter int ROB_W  = 3,
    parameter int LQ_W   = 2,
    parameter int SQ_W   = 2
);
    logic              DC_valid;
    logic              IS_ready;
    logic [XLEN-1:0]   DC_out_pc;
    logic [31:0]       DC_out_inst;
    logic [XLEN-1:0]   DC_out_imm;
    logic [4:0]        DC_out_op;
    logic [2:0]        DC_out_f3;
    logic [6:0]        DC_out_f7;
    logic [PREG_W-1:0] DC_out_P_rs1;
    logic [PREG_W-1:0] DC_out_P_rs2;
    logic [PREG_W-1:0] DC_out_P_rd;
    logic [ROB_W-1:0]  DC_out_rob_idx;
    logic [LQ_W-1:0]   DC_out_LQ_tail;
    logic [SQ_W-1:0]   DC_out_SQ_tail;
    logic [2:0]        DC_out_fu_sel;
    logic              DC_out_jump;

    // queue side
    modport master (
        output DC_valid, DC_out_pc, DC_out_inst, DC_out_imm, DC_out_op,
               DC_out_f3, DC_out_f7, DC_out_P_rs1, DC_out_P_rs2, DC_out_P_rd,
               DC_out_rob_idx, DC_out_LQ_tail, DC_out_SQ_tail, DC_out_fu_sel,
               DC_out_jump,
        input  IS_ready
    );

    // issue side
    modport slave (
        input  DC_valid, DC_out_pc, DC_out_inst, DC_out_imm, DC_out_op,
               DC_out_f3, DC_out_f7, DC_out_P_rs1, DC_out_P_rs2, DC_out_P_rd,
               DC_out_rob_idx, DC_out_LQ_tail, DC_out_SQ_tail, DC_out_fu_sel,
               DC_out_jump,
        output IS_ready
    );
endinterface

// File: rtl/dc_dispatch_queue.sv
// Decode stage plus a DEPTH-entry in-order queue between rename/dispatch
// and issue. Decodes the fetch slot combinationally, enqueues it with its
// rename/ROB/LSQ tags, and redirects early on not-predicted JALs.
module dc_dispatch_queue #(
    parameter int DEPTH  = 4,
    parameter int XLEN   = 32,
    parameter int PREG_W = 7,
    parameter int ROB_W  = 3,
    parameter int LQ_W   = 2,
    parameter int SQ_W   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    // fetch slot
    input  logic                       IF_valid,
    output logic                       DC_ready,
    input  logic [XLEN-1:0]            DC_in_pc,
    input  logic [31:0]                DC_in_inst,
    input  logic                       DC_in_jump,
    // rename / ROB / LSU allocation
    output logic [5:0]                 A_rs1,
    output logic [5:0]                 A_rs2,
    output logic [5:0]                 A_rd,
    output logic                       allocate_rd,
    input  logic [PREG_W-1:0]          P_rs1,
    input  logic [PREG_W-1:0]          P_rs2,
    input  logic [PREG_W-1:0]          P_rd_new,
    input  logic [ROB_W-1:0]           DC_rob_idx,
    input  logic                       rob_ready,
    input  logic [LQ_W-1:0]            LQ_tail,
    input  logic [SQ_W-1:0]            SQ_tail,
    input  logic                       ld_ready,
    input  logic                       st_ready,
    output logic                       decode_valid,
    // control
    input  logic                       mispredict,
    input  logic                       stall,
    output logic                       DC_mispredict,
    output logic [XLEN-1:0]            DC_redirect_pc,
    // issue side
    dc_dispatch_queue_if.master        is_bus,
    output logic [$clog2(DEPTH):0]     DC_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_FLOAD  = 5'b00001;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_FSTORE = 5'b01001;
    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_F      = 5'b10100;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_CSR    = 5'b11100;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [31:0]       inst;
        logic [XLEN-1:0]   imm;
        logic [2:0]        fu_sel;
        logic [PREG_W-1:0] prs1;
        logic [PREG_W-1:0] prs2;
        logic [PREG_W-1:0] prd;
        logic [ROB_W-1:0]  rob_idx;
        logic [LQ_W-1:0]   lq_tail;
        logic [SQ_W-1:0]   sq_tail;
        logic              jump;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;

    logic [4:0]      op;
    logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] imm;
    logic [2:0]      fu_sel;
    logic            is_load, is_store, is_branch, is_jal;
    logic            fp_rs1, fp_rs2, fp_rd;
    logic            lsq_ok, push, pop;
    entry_t          new_entry;

    assign op     = DC_in_inst[6:2];
    assign imm_i  = {{20{DC_in_inst[31]}}, DC_in_inst[31:20]};
    assign imm_s  = {{20{DC_in_inst[31]}}, DC_in_inst[31:25], DC_in_inst[11:7]};
    assign imm_b  = {{20{DC_in_inst[31]}}, DC_in_inst[7], DC_in_inst[30:25],
                     DC_in_inst[11:8], 1'b0};
    assign imm_u  = {DC_in_inst[31:12], 12'h000};
    assign imm_j  = {{12{DC_in_inst[31]}}, DC_in_inst[19:12], DC_in_inst[20],
                     DC_in_inst[30:21], 1'b0};

    // Immediate and functional-unit select by instruction format
    always_comb begin
        imm    = '0;
        fu_sel = 3'd0;
        case (op)
            OP_IMM, OP_LOAD, OP_FLOAD, OP_JALR: imm = XLEN'($signed(imm_i));
            OP_STORE, OP_FSTORE:                imm = XLEN'($signed(imm_s));
            OP_BRANCH:                          imm = XLEN'($signed(imm_b));
            OP_JAL:                             imm = XLEN'($signed(imm_j));
            OP_LUI, OP_AUIPC:                   imm = XLEN'($signed(imm_u));
            OP_CSR:                             imm = XLEN'(DC_in_inst[31:20]);
            default:                            imm = '0;
        endcase
        case (op)
            OP_R:                fu_sel = {2'b00, DC_in_inst[25]};
            OP_F:                fu_sel = 3'd3;
            OP_LOAD, OP_FLOAD:   fu_sel = 3'd6;
            OP_STORE, OP_FSTORE: fu_sel = 3'd7;
            default:             fu_sel = 3'd0;
        endcase
    end

    assign is_load   = (op == OP_LOAD)  || (op == OP_FLOAD);
    assign is_store  = (op == OP_STORE) || (op == OP_FSTORE);
    assign is_branch = (op == OP_BRANCH);
    assign is_jal    = (op == OP_JAL);
    assign fp_rs1    = (op == OP_F);
    assign fp_rs2    = (op == OP_F) || (op == OP_FSTORE);
    assign fp_rd     = (op == OP_F) || (op == OP_FLOAD);

    assign A_rs1       = {fp_rs1, DC_in_inst[19:15]};
    assign A_rs2       = {fp_rs2, DC_in_inst[24:20]};
    assign A_rd        = {fp_rd,  DC_in_inst[11:7]};
    // f0 is a real destination, so the fp flag counts as non-zero
    assign allocate_rd = !(is_store || is_branch) && (A_rd != 6'd0);

    // No bypass: a full queue refuses even when the head pops this cycle
    assign lsq_ok       = (!is_store || st_ready) && (!is_load || ld_ready);
    assign DC_ready     = (count < CW'(DEPTH)) && rob_ready && lsq_ok
                          && !mispredict && !stall;
    assign decode_valid = IF_valid && DC_ready;
    assign push         = decode_valid;
    assign pop          = is_bus.DC_valid && is_bus.IS_ready;

    // A JAL that fetch did not predict is redirected here and then
    // travels as a taken jump
    assign DC_mispredict  = decode_valid && is_jal && !DC_in_jump;
    assign DC_redirect_pc = DC_in_pc + XLEN'($signed(imm_j));

    assign new_entry = '{
        pc:      DC_in_pc,
        inst:    DC_in_inst,
        imm:     imm,
        fu_sel:  fu_sel,
        prs1:    P_rs1,
        prs2:    P_rs2,
        prd:     P_rd_new,
        rob_idx: DC_rob_idx,
        lq_tail: LQ_tail,
        sq_tail: SQ_tail,
        jump:    DC_in_jump || is_jal
    };

    // Queue state: flush beats push/pop, otherwise push at tail, pop at head
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (mispredict) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign DC_count              = count;
    assign is_bus.DC_valid       = (count != '0);
    assign is_bus.DC_out_pc      = mem[rd_ptr].pc;
    assign is_bus.DC_out_inst    = mem[rd_ptr].inst;
    assign is_bus.DC_out_imm     = mem[rd_ptr].imm;
    assign is_bus.DC_out_op      = mem[rd_ptr].inst[6:2];
    assign is_bus.DC_out_f3      = mem[rd_ptr].inst[14:12];
    assign is_bus.DC_out_f7      = mem[rd_ptr].inst[31:25];
    assign is_bus.DC_out_P_rs1   = mem[rd_ptr].prs1;
    assign is_bus.DC_out_P_rs2   = mem[rd_ptr].prs2;
    assign is_bus.DC_out_P_rd    = mem[rd_ptr].prd;
    assign is_bus.DC_out_rob_idx = mem[rd_ptr].rob_idx;
    assign is_bus.DC_out_LQ_tail = mem[rd_ptr].lq_tail;
    assign is_bus.DC_out_SQ_tail = mem[rd_ptr].sq_tail;
    assign is_bus.DC_out_fu_sel  = mem[rd_ptr].fu_sel;
    assign is_bus.DC_out_jump    = mem[rd_ptr].jump;
endmodule

// File: tb/tb_dc_dispatch_queue.sv
// Bench for dc_dispatch_queue: directed scenarios plus a randomized run,
// all checked against a queue-based reference model.
module tb_dc_dispatch_queue;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        if_valid, in_jump, rob_ready, ld_ready, st_ready;
    logic        mispredict, stall, is_ready;
    logic [31:0] in_pc, in_inst;
    logic [6:0]  p_rs1, p_rs2, p_rd;
    logic [2:0]  rob_idx;
    logic [1:0]  lq_tail, sq_tail;

    logic        dc_ready, decode_valid, dc_mispredict, allocate_rd;
    logic [5:0]  a_rs1, a_rs2, a_rd;
    logic [31:0] redirect_pc;
    logic [2:0]  dc_count;

    dc_dispatch_queue_if #(.XLEN(32), .PREG_W(7), .ROB_W(3), .LQ_W(2), .SQ_W(2)) is_bus ();
    assign is_bus.IS_ready = is_ready;

    dc_dispatch_queue #(.DEPTH(DEPTH), .XLEN(32), .PREG_W(7), .ROB_W(3),
                        .LQ_W(2), .SQ_W(2)) dut (
        .clk(clk), .rst(rst),
        .IF_valid(if_valid), .DC_ready(dc_ready), .DC_in_pc(in_pc),
        .DC_in_inst(in_inst), .DC_in_jump(in_jump),
        .A_rs1(a_rs1), .A_rs2(a_rs2), .A_rd(a_rd), .allocate_rd(allocate_rd),
        .P_rs1(p_rs1), .P_rs2(p_rs2), .P_rd_new(p_rd), .DC_rob_idx(rob_idx),
        .rob_ready(rob_ready), .LQ_tail(lq_tail), .SQ_tail(sq_tail),
        .ld_ready(ld_ready), .st_ready(st_ready), .decode_valid(decode_valid),
        .mispredict(mispredict), .stall(stall), .DC_mispredict(dc_mispredict),
        .DC_redirect_pc(redirect_pc), .is_bus(is_bus), .DC_count(dc_count)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        jump;
        logic [6:0]  prd;
        logic [2:0]  rob;
        logic [1:0]  lq;
        logic [1:0]  sq;
    } ent_t;

    ent_t mq[$];
    int   checks   = 0;
    int   failures = 0;

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_imm(input logic [31:0] i);
        logic [31:0] t;
        t = $signed(i) >>> 20;
        case (i[6:2])
            5'h00, 5'h01, 5'h04, 5'h19: return t;
            5'h08, 5'h09:               return {t[31:5], i[11:7]};
            5'h18: return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            5'h1B: return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            5'h05, 5'h0D:               return {i[31:12], 12'h000};
            5'h1C:                      return i >> 20;
            default:                    return 32'h0;
        endcase
    endfunction

    function automatic logic [2:0] m_fu(input logic [31:0] i);
        case (i[6:2])
            5'h0C:        return {2'b00, i[25]};
            5'h14:        return 3'd3;
            5'h00, 5'h01: return 3'd6;
            5'h08, 5'h09: return 3'd7;
            default:      return 3'd0;
        endcase
    endfunction

    function automatic bit m_load(input logic [31:0] i);
        return i[6:2] == 5'h00 || i[6:2] == 5'h01;
    endfunction

    function automatic bit m_store(input logic [31:0] i);
        return i[6:2] == 5'h08 || i[6:2] == 5'h09;
    endfunction

    function automatic bit m_ready();
        return mq.size() < DEPTH && rob_ready && !mispredict && !stall
               && (!m_store(in_inst) || st_ready) && (!m_load(in_inst) || ld_ready);
    endfunction

    function automatic logic [31:0] addi(input int rd, input int rs1, input int im);
        logic [11:0] imm12;
        imm12 = 12'(im);
        return {imm12, 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
    endfunction

    // one clock, updating the model with what the DUT should have done
    task automatic tick();
        bit   push, pop;
        ent_t e;
        push    = if_valid && m_ready();
        pop     = mq.size() > 0 && is_ready;
        e.pc    = in_pc;
        e.inst  = in_inst;
        e.jump  = in_jump || (in_inst[6:2] == 5'h1B);
        e.prd   = p_rd;
        e.rob   = rob_idx;
        e.lq    = lq_tail;
        e.sq    = sq_tail;
        @(posedge clk);
        if (mispredict) mq.delete();
        else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(e);
        end
        #1;
    endtask

    task automatic idle();
        if_valid = 0; in_jump = 0; rob_ready = 1; ld_ready = 1; st_ready = 1;
        mispredict = 0; stall = 0; is_ready = 0; in_pc = 0; in_inst = 32'h13;
        p_rs1 = 0; p_rs2 = 0; p_rd = 0; rob_idx = 0; lq_tail = 0; sq_tail = 0;
    endtask

    task automatic drain();
        if_valid = 0; is_ready = 1; mispredict = 0; stall = 0;
        repeat (DEPTH + 1) tick();
        is_ready = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle();
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (is_bus.DC_valid !== 1'b0 || dc_count !== 3'd0) begin
            failures++;
            $display("FAIL reset: valid=%b count=%0d expected 0/0", is_bus.DC_valid, dc_count);
        end
        rst = 1;
        tick();
    endtask

    task automatic test_async_reset();
        idle();
        if_valid = 1;
        for (int k = 0; k < 3; k++) begin
            in_pc = 32'h1000 + 32'(4 * k); in_inst = addi(k + 1, 0, k);
            tick();
        end
        if_valid = 0;
        #2 rst = 0;
        #1;
        checks++;
        if (is_bus.DC_valid !== 1'b0 || dc_count !== 3'd0) begin
            failures++;
            $display("FAIL async_reset: valid=%b count=%0d expected 0/0", is_bus.DC_valid, dc_count);
        end
        #1 rst = 1;
        mq.delete();
        in_pc = 32'h40; in_inst = addi(3, 1, 7); if_valid = 1;
        tick();
        if_valid = 0;
        checks++;
        if (is_bus.DC_out_pc !== 32'h40 || dc_count !== 3'd1) begin
            failures++;
            $display("FAIL async_reset_push: pc=%h count=%0d expected 40/1", is_bus.DC_out_pc, dc_count);
        end
        drain();
    endtask

    task automatic test_full_drain();
        idle();
        if_valid = 1;
        for (int k = 0; k < 4; k++) begin
            in_pc = 32'(4 * k); in_inst = addi(k + 1, 0, k);
            tick();
        end
        in_pc = 32'h10; in_inst = addi(9, 0, 9);
        #1;
        checks++;
        if (dc_ready !== 1'b0 || dc_count !== 3'd4) begin
            failures++;
            $display("FAIL full: ready=%b count=%0d expected 0/4", dc_ready, dc_count);
        end
        tick();
        checks++;
        if (dc_count !== 3'd4) begin
            failures++;
            $display("FAIL full_hold: count=%0d expected 4", dc_count);
        end
        if_valid = 0; is_ready = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (is_bus.DC_valid !== 1'b1 || is_bus.DC_out_pc !== 32'(4 * k)) begin
                failures++;
                $display("FAIL drain_order: pc=%h expected %h", is_bus.DC_out_pc, 32'(4 * k));
            end
            tick();
        end
        checks++;
        if (dc_count !== 3'd0 || is_bus.DC_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_empty: count=%0d valid=%b expected 0/0", dc_count, is_bus.DC_valid);
        end
        is_ready = 0;
    endtask

    task automatic test_store_gating();
        idle();
        // sw x5,-4(x2)
        in_inst = {7'h7f, 5'd5, 5'd2, 3'b010, 5'h1c, 7'b0100011};
        in_pc = 32'h80; if_valid = 1; st_ready = 0;
        #1;
        checks++;
        if (dc_ready !== 1'b0 || decode_valid !== 1'b0) begin
            failures++;
            $display("FAIL store_blocked: ready=%b dv=%b expected 0/0", dc_ready, decode_valid);
        end
        tick();
        st_ready = 1;
        #1;
        checks++;
        if (decode_valid !== 1'b1 || allocate_rd !== 1'b0) begin
            failures++;
            $display("FAIL store_accept: dv=%b alloc_rd=%b expected 1/0", decode_valid, allocate_rd);
        end
        tick();
        if_valid = 0;
        checks++;
        if (is_bus.DC_out_fu_sel !== 3'd7 || is_bus.DC_out_imm !== 32'hFFFFFFFC || dc_count !== 3'd1) begin
            failures++;
            $display("FAIL store_entry: fu=%0d imm=%h count=%0d expected 7/fffffffc/1",
                     is_bus.DC_out_fu_sel, is_bus.DC_out_imm, dc_count);
        end
        drain();
    endtask

    task automatic test_early_jal();
        idle();
        // jal x1,+0x20 at pc 0x100
        in_inst = {1'b0, 10'h010, 1'b0, 8'h00, 5'd1, 7'b1101111};
        in_pc = 32'h100; in_jump = 0; if_valid = 1;
        #1;
        checks++;
        if (dc_mispredict !== 1'b1 || redirect_pc !== 32'h120) begin
            failures++;
            $display("FAIL jal_redirect: misp=%b pc=%h expected 1/120", dc_mispredict, redirect_pc);
        end
        tick();
        if_valid = 0;
        checks++;
        if (is_bus.DC_out_jump !== 1'b1 || is_bus.DC_out_imm !== 32'h20) begin
            failures++;
            $display("FAIL jal_entry: jump=%b imm=%h expected 1/20", is_bus.DC_out_jump, is_bus.DC_out_imm);
        end
        if_valid = 1; rob_ready = 0;
        #1;
        checks++;
        if (dc_mispredict !== 1'b0 || decode_valid !== 1'b0) begin
            failures++;
            $display("FAIL jal_blocked: misp=%b dv=%b expected 0/0", dc_mispredict, decode_valid);
        end
        rob_ready = 1;
        drain();
    endtask

    task automatic test_flush();
        idle();
        if_valid = 1;
        for (int k = 0; k < 2; k++) begin
            in_pc = 32'h180 + 32'(4 * k); in_inst = addi(k + 4, 0, k);
            tick();
        end
        in_pc = 32'h200; in_inst = addi(7, 0, 1); is_ready = 1; mispredict = 1;
        #1;
        checks++;
        if (decode_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_dv: dv=%b expected 0", decode_valid);
        end
        tick();
        checks++;
        if (dc_count !== 3'd0 || is_bus.DC_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush: count=%0d valid=%b expected 0/0", dc_count, is_bus.DC_valid);
        end
        mispredict = 0; is_ready = 0; in_pc = 32'h300;
        tick();
        if_valid = 0;
        checks++;
        if (is_bus.DC_out_pc !== 32'h300 || dc_count !== 3'd1) begin
            failures++;
            $display("FAIL flush_refill: pc=%h count=%0d expected 300/1", is_bus.DC_out_pc, dc_count);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        idle();
        if_valid = 1;
        for (int k = 0; k < 2; k++) begin
            in_pc = 32'h500 + 32'(4 * k); in_inst = addi(k + 1, 0, k);
            tick();
        end
        is_ready = 1;
        for (int k = 0; k < 10; k++) begin
            in_pc = 32'h508 + 32'(4 * k); in_inst = addi(k + 3, 0, k);
            tick();
            checks++;
            if (dc_count !== 3'd2 || is_bus.DC_out_pc !== 32'h500 + 32'(4 * (k + 1))) begin
                failures++;
                $display("FAIL back_to_back[%0d]: count=%0d pc=%h expected 2/%h",
                         k, dc_count, is_bus.DC_out_pc, 32'h500 + 32'(4 * (k + 1)));
            end
        end
        drain();
    endtask

    task automatic test_random();
        logic [4:0] ops [13] = '{5'h00, 5'h01, 5'h04, 5'h05, 5'h08, 5'h09, 5'h0C,
                                 5'h0D, 5'h14, 5'h18, 5'h19, 5'h1B, 5'h1C};
        logic [31:0] r;
        bit   exp_rdy, exp_dv, exp_misp, fpd;
        idle();
        for (int c = 0; c < 400; c++) begin
            r = $urandom();
            in_inst    = {r[31:7], ops[$urandom_range(12)], 2'b11};
            in_pc      = $urandom() & 32'hFFFF_FFFC;
            in_jump    = ($urandom_range(3) == 0);
            if_valid   = ($urandom_range(3) != 0);
            is_ready   = ($urandom_range(9) < 6);
            rob_ready  = ($urandom_range(9) != 0);
            ld_ready   = ($urandom_range(4) != 0);
            st_ready   = ($urandom_range(4) != 0);
            stall      = ($urandom_range(9) == 0);
            mispredict = ($urandom_range(19) == 0);
            p_rs1 = 7'($urandom()); p_rs2 = 7'($urandom()); p_rd = 7'($urandom());
            rob_idx = 3'($urandom()); lq_tail = 2'($urandom()); sq_tail = 2'($urandom());
            #1;
            exp_rdy  = m_ready();
            exp_dv   = exp_rdy && if_valid;
            exp_misp = exp_dv && in_inst[6:2] == 5'h1B && !in_jump;
            fpd      = in_inst[6:2] == 5'h14 || in_inst[6:2] == 5'h01;
            checks++;
            if (dc_ready !== exp_rdy || decode_valid !== exp_dv || dc_mispredict !== exp_misp) begin
                failures++;
                $display("FAIL rnd_accept[%0d]: ready=%b dv=%b misp=%b expected %b/%b/%b",
                         c, dc_ready, decode_valid, dc_mispredict, exp_rdy, exp_dv, exp_misp);
            end
            checks++;
            if (a_rd !== {fpd, in_inst[11:7]} ||
                allocate_rd !== (!m_store(in_inst) && in_inst[6:2] != 5'h18 && {fpd, in_inst[11:7]} != 6'd0)) begin
                failures++;
                $display("FAIL rnd_rename[%0d]: A_rd=%h alloc=%b inst=%h", c, a_rd, allocate_rd, in_inst);
            end
            if (exp_misp) begin
                checks++;
                if (redirect_pc !== in_pc + m_imm(in_inst)) begin
                    failures++;
                    $display("FAIL rnd_redirect[%0d]: pc=%h expected %h", c, redirect_pc, in_pc + m_imm(in_inst));
                end
            end
            checks++;
            if (dc_count !== 3'(mq.size()) || is_bus.DC_valid !== (mq.size() != 0)) begin
                failures++;
                $display("FAIL rnd_count[%0d]: count=%0d valid=%b expected %0d", c, dc_count, is_bus.DC_valid, mq.size());
            end
            if (mq.size() != 0) begin
                checks++;
                if (is_bus.DC_out_pc !== mq[0].pc || is_bus.DC_out_inst !== mq[0].inst ||
                    is_bus.DC_out_imm !== m_imm(mq[0].inst) || is_bus.DC_out_fu_sel !== m_fu(mq[0].inst) ||
                    is_bus.DC_out_op !== mq[0].inst[6:2] || is_bus.DC_out_jump !== mq[0].jump ||
                    is_bus.DC_out_P_rd !== mq[0].prd || is_bus.DC_out_rob_idx !== mq[0].rob ||
                    is_bus.DC_out_LQ_tail !== mq[0].lq || is_bus.DC_out_SQ_tail !== mq[0].sq) begin
                    failures++;
                    $display("FAIL rnd_head[%0d]: pc=%h inst=%h imm=%h fu=%0d jump=%b expected %h/%h/%h/%0d/%b",
                             c, is_bus.DC_out_pc, is_bus.DC_out_inst, is_bus.DC_out_imm,
                             is_bus.DC_out_fu_sel, is_bus.DC_out_jump, mq[0].pc, mq[0].inst,
                             m_imm(mq[0].inst), m_fu(mq[0].inst), mq[0].jump);
                end
            end
            tick();
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_full_drain();
        test_store_gating();
        test_early_jal();
        test_flush();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
